// File: rtl/instr_fetch_if.sv
// instr_fetch_if: control, program-load and instruction-output bundle of the
// instr_fetch engine. The master drives start/stall/program-load; the slave
// (instr_fetch) returns the registered instruction, pulse, pc and status.
interface instr_fetch_if #(
    parameter int unsigned MEM_WORDS = 64
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic          start;
    logic          stall;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic [31:0]   instrword;
    logic          newinstr;
    logic [31:0]   pc;
    logic          busy;
    logic          halted;

    modport master (
        output start,
        output stall,
        output prog_we,
        output prog_addr,
        output prog_data,
        input  instrword,
        input  newinstr,
        input  pc,
        input  busy,
        input  halted
    );

    modport slave (
        input  start,
        input  stall,
        input  prog_we,
        input  prog_addr,
        input  prog_data,
        output instrword,
        output newinstr,
        output pc,
        output busy,
        output halted
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetcher with an internal instruction
// store. Each instruction walks FETCH -> ISSUE -> WAIT (CPI unstalled cycles),
// so consecutive newinstr pulses are CPI+2 cycles apart without stalls.
// Fetching the word 32'hFC000000 parks the engine in HALT until reset.
// MEM_WORDS must be a power of two (pc wraps modulo 4*MEM_WORDS).
//
// Optional feature: define INSTR_FETCH_BRANCH_EN to add the branch_taken
// input. A branch seen during WAIT redirects the next pc to
// pc + 4 + (sign-extended instrword[15:0] << 2).
module instr_fetch #(
    parameter int unsigned CPI       = 4,
    parameter int unsigned MEM_WORDS = 64
) (
    input logic          clock,
    input logic          reset,
    instr_fetch_if.slave bus
`ifdef INSTR_FETCH_BRANCH_EN
    ,
    input logic          branch_taken
`endif
);
    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam int unsigned CW       = (CPI > 1) ? $clog2(CPI) : 1;
    localparam logic [31:0] HaltWord = 32'hFC00_0000;
    localparam logic [CW-1:0] CntLoad = CW'(CPI - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StHalt
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;       // word index; pc output is this << 2
    logic [31:0]   instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mem_q [MEM_WORDS];

    logic [31:0]   fetch_word;
    logic [31:0]   branch_words;
    logic [AW-1:0] pc_step;
    logic          take_branch;
    logic          busy;

    assign busy       = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait);
    assign fetch_word = mem_q[pc_q];

    // Branch offset in words: 1 (the normal +4) plus the sign-extended immediate.
    assign branch_words = 32'd1 + {{16{instr_q[15]}}, instr_q[15:0]};
    assign pc_step      = take_branch ? branch_words[AW-1:0] : AW'(1);

`ifdef INSTR_FETCH_BRANCH_EN
    logic br_q, br_d;

    // Branch latch: cleared on entry to WAIT, set by branch_taken on any WAIT cycle.
    always_comb begin
        br_d = br_q;
        if (state_q == StIssue) begin
            br_d = 1'b0;
        end else if ((state_q == StWait) && branch_taken) begin
            br_d = 1'b1;
        end
    end

    // Branch latch register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            br_q <= 1'b0;
        end else begin
            br_q <= br_d;
        end
    end

    // A branch flagged on the exit cycle itself still counts.
    assign take_branch = br_q | branch_taken;
`else
    assign take_branch = 1'b0;
`endif

    // Instruction store: written only while idle or halted, and never cleared by reset.
    always_ff @(posedge clock) begin
        if (reset && bus.prog_we && !busy) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Next-state logic for the fetch FSM, pc, instruction register and CPI counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                instr_d = fetch_word;
                state_d = (fetch_word == HaltWord) ? StHalt : StIssue;
            end
            StIssue: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (!bus.stall) begin
                    if (cnt_q == '0) begin
                        pc_d    = pc_q + pc_step;
                        state_d = StFetch;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.instrword = instr_q;
    assign bus.newinstr  = (state_q == StIssue);
    assign bus.pc        = 32'({pc_q, 2'b00});
    assign bus.busy      = busy;
    assign bus.halted    = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven scenarios, hand-written reset/program-load and
// wrap sequences, and randomized stall runs compared with a timing model that
// derives pulse times and addresses directly from CPI and the stall pattern.
module tb_instr_fetch;
    localparam int unsigned CPI  = 4;
    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam int NV = 6;
    localparam int NR = 200;

    logic clock;
    logic reset;

    instr_fetch_if #(.MEM_WORDS(64)) bus ();
    instr_fetch_if #(.MEM_WORDS(4))  bus4 ();

`ifdef INSTR_FETCH_BRANCH_EN
    logic branch_taken;
    logic branch_taken4;
    bit   br_pat [256];
`endif

    instr_fetch #(.CPI(CPI), .MEM_WORDS(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef INSTR_FETCH_BRANCH_EN
        ,
        .branch_taken (branch_taken)
`endif
    );

    instr_fetch #(.CPI(CPI), .MEM_WORDS(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
`ifdef INSTR_FETCH_BRANCH_EN
        ,
        .branch_taken (branch_taken4)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] w0, w1, w2;
        int          stall_at, stall_len;
        int          exp_pulses;
        int          exp_gap;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [NV];
    int          checks, failures;
    int          cyc, k0;
    bit          stall_pat [256];
    int          pk[$];
    logic [31:0] pw[$];
    logic [31:0] pp[$];
    logic [31:0] mdl [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic clear_pats();
        for (int i = 0; i < 256; i++) begin
            stall_pat[i] = 1'b0;
`ifdef INSTR_FETCH_BRANCH_EN
            br_pat[i] = 1'b0;
`endif
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.prog_we   = 1'b0;
        bus4.start    = 1'b0;
        bus4.stall    = 1'b0;
        bus4.prog_we  = 1'b0;
`ifdef INSTR_FETCH_BRANCH_EN
        branch_taken  = 1'b0;
        branch_taken4 = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic prog(input int a, input logic [31:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a[5:0];
        bus.prog_data = d;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    // Raise start for one cycle; pulse times are then relative to that cycle.
    task automatic launch();
        pk.delete();
        pw.delete();
        pp.delete();
        k0        = cyc;
        bus.start = 1'b1;
        bus.stall = stall_pat[0];
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run(input int n);
        int rel;
        for (int i = 0; i < n; i++) begin
            rel = cyc - k0;
            if (bus.newinstr === 1'b1) begin
                pk.push_back(rel);
                pw.push_back(bus.instrword);
                pp.push_back(bus.pc);
            end
            bus.stall = (rel >= 0 && rel < 256) ? stall_pat[rel] : 1'b0;
`ifdef INSTR_FETCH_BRANCH_EN
            branch_taken = (rel >= 0 && rel < 256) ? br_pat[rel] : 1'b0;
`endif
            tick();
        end
    endtask

    initial begin
        int          ek[$];
        logic [31:0] ew[$];
        logic [31:0] ep[$];
        int          f, p, e, need, halt_at, a, hpos, n4;
        logic [31:0] w;
        logic [31:0] p4[$];
        logic [31:0] w4[$];

        checks   = 0;
        failures = 0;
        cyc      = 0;
        k0       = 0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus4.prog_addr = '0;
        bus4.prog_data = '0;
        clear_pats();

        //                 w0            w1            w2     stall_at len pulses gap pc
        vecs[0] = '{32'h012A4020, 32'h8D090004, HALT,         0, 0, 2, 6, 32'd8};
        vecs[1] = '{32'h012A4020, 32'h8D090004, HALT,         4, 3, 2, 9, 32'd8};
        vecs[2] = '{32'h012A4020, 32'h8D090004, HALT,         6, 1, 2, 7, 32'd8};
        vecs[3] = '{32'h012A4020, HALT,         32'h0,        0, 0, 1, 0, 32'd4};
        vecs[4] = '{HALT,         32'h8D090004, 32'h0,        0, 0, 0, 0, 32'd0};
        vecs[5] = '{32'h012A4020, 32'h8D090004, HALT,         1, 2, 2, 6, 32'd8};

        // Reset state.
        do_reset();
        check("rst_pc", bus.pc, 32'd0);
        check("rst_instrword", bus.instrword, 32'd0);
        check("rst_newinstr", 32'(bus.newinstr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);

        // Table-driven scenarios.
        for (int i = 0; i < NV; i++) begin
            do_reset();
            prog(0, vecs[i].w0);
            prog(1, vecs[i].w1);
            prog(2, vecs[i].w2);
            clear_pats();
            for (int s = 0; s < vecs[i].stall_len; s++) stall_pat[vecs[i].stall_at + s] = 1'b1;
            launch();
            run(40);
            check($sformatf("row%0d_pulses", i), 32'(pk.size()), 32'(vecs[i].exp_pulses));
            if (vecs[i].exp_pulses >= 1 && pk.size() >= 1) begin
                check($sformatf("row%0d_first_at", i), 32'(pk[0]), 32'd2);
                check($sformatf("row%0d_instr0", i), pw[0], vecs[i].w0);
                check($sformatf("row%0d_pc0", i), pp[0], 32'd0);
            end
            if (vecs[i].exp_pulses >= 2 && pk.size() >= 2) begin
                check($sformatf("row%0d_gap", i), 32'(pk[1] - pk[0]), 32'(vecs[i].exp_gap));
                check($sformatf("row%0d_instr1", i), pw[1], vecs[i].w1);
                check($sformatf("row%0d_pc1", i), pp[1], 32'd4);
            end
            check($sformatf("row%0d_halted", i), 32'(bus.halted), 32'd1);
            check($sformatf("row%0d_halt_pc", i), bus.pc, vecs[i].exp_pc);
            check($sformatf("row%0d_busy", i), 32'(bus.busy), 32'd0);
            check($sformatf("row%0d_halt_word", i), bus.instrword, HALT);
        end

        // Reset in the second WAIT cycle, with start and prog_we asserted alongside.
        do_reset();
        prog(0, 32'h012A4020);
        prog(1, 32'h8D090004);
        prog(2, HALT);
        clear_pats();
        launch();
        run(3);
        reset         = 1'b0;
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 6'd0;
        bus.prog_data = 32'h1111_1111;
        tick();
        check("midwait_rst_busy", 32'(bus.busy), 32'd0);
        check("midwait_rst_pc", bus.pc, 32'd0);
        check("midwait_rst_newinstr", 32'(bus.newinstr), 32'd0);
        check("midwait_rst_instrword", bus.instrword, 32'd0);
        check("midwait_rst_halted", 32'(bus.halted), 32'd0);
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        run(10);
        check("midwait_pulse_count", 32'(pk.size()), 32'd1);
        check("midwait_still_idle", 32'(bus.busy), 32'd0);
        launch();
        run(12);
        check("after_rst_pulses", 32'(pk.size()), 32'd2);
        if (pk.size() >= 1) begin
            check("after_rst_first_at", 32'(pk[0]), 32'd2);
            check("store_kept_word0", pw[0], 32'h012A4020);
        end

        // Writes while busy are dropped; start is ignored while busy and halted.
        do_reset();
        clear_pats();
        launch();
        run(2);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 6'd1;
        bus.prog_data = 32'hDEAD_BEEF;
        bus.start     = 1'b1;
        run(1);
        bus.prog_we   = 1'b0;
        bus.start     = 1'b0;
        run(30);
        check("busy_wr_pulses", 32'(pk.size()), 32'd2);
        if (pk.size() >= 2) begin
            check("busy_wr_gap", 32'(pk[1] - pk[0]), 32'd6);
            check("busy_wr_ignored", pw[1], 32'h8D090004);
        end
        bus.start = 1'b1;
        run(1);
        bus.start = 1'b0;
        run(10);
        check("halt_start_pulses", 32'(pk.size()), 32'd2);
        check("halt_start_halted", 32'(bus.halted), 32'd1);
        check("halt_start_pc", bus.pc, 32'd8);
        do_reset();
        prog(1, 32'hDEAD_BEEF);
        launch();
        run(12);
        check("idle_wr_pulses", 32'(pk.size()), 32'd2);
        if (pk.size() >= 2) check("idle_wr_applied", pw[1], 32'hDEAD_BEEF);

        // Four-word store wraps from the last word back to address 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus4.prog_we   = 1'b1;
            bus4.prog_addr = i[1:0];
            bus4.prog_data = 32'(32'h100 + i);
            tick();
        end
        bus4.prog_we = 1'b0;
        bus4.start   = 1'b1;
        tick();
        bus4.start   = 1'b0;
        for (int j = 0; j < 30; j++) begin
            if (bus4.newinstr === 1'b1) begin
                p4.push_back(bus4.pc);
                w4.push_back(bus4.instrword);
            end
            tick();
        end
        check("wrap_pulses", 32'(p4.size()), 32'd5);
        n4 = (p4.size() < 5) ? p4.size() : 5;
        for (int j = 0; j < n4; j++) begin
            check($sformatf("wrap_pc%0d", j), p4[j], 32'((j % 4) * 4));
            check($sformatf("wrap_instr%0d", j), w4[j], 32'(32'h100 + (j % 4)));
        end

`ifdef INSTR_FETCH_BRANCH_EN
        // Branch to self: offset -1 word cancels the +4, so word 0 is reissued.
        do_reset();
        prog(0, 32'h1000_FFFF);
        prog(1, 32'h2222_2222);
        prog(2, HALT);
        clear_pats();
        br_pat[4] = 1'b1;
        launch();
        run(30);
        check("br_pulses", 32'(pk.size()), 32'd3);
        if (pk.size() >= 3) begin
            check("br_pc1", pp[1], 32'd0);
            check("br_instr1", pw[1], 32'h1000_FFFF);
            check("br_gap", 32'(pk[1] - pk[0]), 32'd6);
            check("br_pc2", pp[2], 32'd4);
            check("br_instr2", pw[2], 32'h2222_2222);
        end
        check("br_halt_pc", bus.pc, 32'd8);
        clear_pats();
`endif

        // Randomized stall runs against the timing model.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            hpos = int'($urandom_range(2, 7));
            for (int i = 0; i < 64; i++) begin
                w = $urandom;
                if (w == HALT) w = w ^ 32'h1;
                mdl[i] = w;
            end
            mdl[hpos] = HALT;
            for (int i = 0; i <= hpos; i++) prog(i, mdl[i]);
            clear_pats();
            for (int i = 0; i < 256; i++) stall_pat[i] = ($urandom_range(0, 2) == 0);

            // Model: FETCH at f, pulse at f+1, then CPI unstalled cycles before next FETCH.
            ek.delete();
            ew.delete();
            ep.delete();
            f = 1;
            a = 0;
            halt_at = -1;
            while (f < NR) begin
                if (mdl[a] == HALT) begin
                    halt_at = f + 1;
                    break;
                end
                p = f + 1;
                if (p > NR - 1) break;
                ek.push_back(p);
                ew.push_back(mdl[a]);
                ep.push_back(32'(a * 4));
                need = CPI;
                e = p;
                while (need > 0 && e < 255) begin
                    e++;
                    if (!stall_pat[e]) need--;
                end
                if (need > 0) break;
                f = e + 1;
                a = (a + 1) % 64;
            end

            launch();
            run(NR - 1);
            check($sformatf("rnd%0d_pulses", it), 32'(pk.size()), 32'(ek.size()));
            for (int i = 0; i < ek.size() && i < pk.size(); i++) begin
                check($sformatf("rnd%0d_t%0d", it, i), 32'(pk[i]), 32'(ek[i]));
                check($sformatf("rnd%0d_w%0d", it, i), pw[i], ew[i]);
                check($sformatf("rnd%0d_pc%0d", it, i), pp[i], ep[i]);
            end
            check($sformatf("rnd%0d_halted", it), 32'(bus.halted),
                  32'(halt_at >= 0 && halt_at <= NR));
            if (halt_at >= 0 && halt_at <= NR) begin
                check($sformatf("rnd%0d_halt_pc", it), bus.pc, 32'(a * 4));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
